// File: rtl/wbm_bridge.sv
// Wishbone B4 classic single-transfer master bridge: latch one request, run a registered CYC/STB cycle, return ACK/ERR.
// Optional watchdog under WBM_TIMEOUT_EN. Latency: 1 cycle to bus, response 1 cycle after slave ACK/ERR. rdy_o low while busy.
module wbm_bridge #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            wbm_we_i,
  input  logic            wbm_re_i,
  input  logic            wbm_kill_i,
  input  logic [AW-1:0]   wbm_adr_i,
  input  logic [DW-1:0]   wbm_dat_i,
  input  logic [DW/8-1:0] wbm_sel_i,
  output logic            wbm_rdy_o,
  output logic            wbm_ack_o,
  output logic            wbm_err_o,
  output logic            wbm_tout_o,
  output logic [DW-1:0]   wbm_dat_o,
  output logic            wbs_cyc_o,
  output logic            wbs_stb_o,
  output logic            wbs_we_o,
  output logic [AW-1:0]   wbs_adr_o,
  output logic [DW-1:0]   wbs_dat_o,
  output logic [DW/8-1:0] wbs_sel_o,
  input  logic [DW-1:0]   wbs_dat_i,
  input  logic            wbs_ack_i,
  input  logic            wbs_err_i
);

  typedef enum logic {IDLE = 1'b0, BUS = 1'b1} state_e;

  state_e            state_q, state_d;
  logic              ack_q, ack_d, err_q, err_d, tout_q, tout_d;
  logic              we_q, we_d;
  logic [AW-1:0]     adr_q, adr_d;
  logic [DW-1:0]     wdat_q, wdat_d, rdat_q, rdat_d;
  logic [DW/8-1:0]   sel_q, sel_d;
  logic              req_ok;
  logic              tout_hit;

  // Both we and re high is illegal and silently dropped.
  assign req_ok = wbm_we_i ^ wbm_re_i;

`ifdef WBM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  assign tout_hit = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE)
      cnt_d = '0;
    else if (!wbm_kill_i && !wbs_err_i && !wbs_ack_i && !tout_hit)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  assign tout_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_ok) state_d = BUS;
      BUS:  if (wbm_kill_i || wbs_err_i || wbs_ack_i || tout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack_d  = 1'b0;
    err_d  = 1'b0;
    tout_d = 1'b0;
    we_d   = we_q;
    adr_d  = adr_q;
    wdat_d = wdat_q;
    sel_d  = sel_q;
    rdat_d = rdat_q;
    case (state_q)
      IDLE: begin
        if (req_ok) begin
          we_d   = wbm_we_i;
          adr_d  = wbm_adr_i;
          wdat_d = wbm_dat_i;
          sel_d  = wbm_sel_i;
        end
      end
      BUS: begin
        // Kill discards any slave response arriving in the same cycle.
        if (!wbm_kill_i) begin
          if (wbs_err_i) begin
            err_d = 1'b1;
          end else if (wbs_ack_i) begin
            ack_d = 1'b1;
            if (!we_q) rdat_d = wbs_dat_i;
          end else if (tout_hit) begin
            err_d  = 1'b1;
            tout_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      tout_q <= 1'b0;
      we_q   <= 1'b0;
      adr_q  <= '0;
      wdat_q <= '0;
      sel_q  <= '0;
      rdat_q <= '0;
    end else begin
      ack_q  <= ack_d;
      err_q  <= err_d;
      tout_q <= tout_d;
      we_q   <= we_d;
      adr_q  <= adr_d;
      wdat_q <= wdat_d;
      sel_q  <= sel_d;
      rdat_q <= rdat_d;
    end
  end

  assign wbm_rdy_o  = (state_q == IDLE);
  assign wbs_cyc_o  = (state_q == BUS);
  assign wbs_stb_o  = (state_q == BUS);
  assign wbm_ack_o  = ack_q;
  assign wbm_err_o  = err_q;
  assign wbm_tout_o = tout_q;
  assign wbm_dat_o  = rdat_q;
  assign wbs_we_o   = we_q;
  assign wbs_adr_o  = adr_q;
  assign wbs_dat_o  = wdat_q;
  assign wbs_sel_o  = sel_q;

endmodule

// File: tb/tb_wbm_bridge.sv
// Scoreboard bench for wbm_bridge: directed transfers, responses checked by an independent monitor.
module tb_wbm_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0, re = 1'b0, kill = 1'b0;
  logic [31:0] adr = '0, wdat = '0;
  logic [3:0]  sel = '0;
  logic        rdy_o, ack_o, err_o, tout_o;
  logic [31:0] dat_o;
  logic        cyc_o, stb_o, swe_o;
  logic [31:0] sadr_o, sdat_o;
  logic [3:0]  ssel_o;
  logic [31:0] sdat_i = '0;
  logic        sack_i = 1'b0, serr_i = 1'b0;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        ack;
    logic        err;
    logic        tout;
    logic [31:0] dat;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [31:0] exp_rdata = '0;

  always #5 clk = ~clk;

  wbm_bridge #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wbm_we_i(we), .wbm_re_i(re), .wbm_kill_i(kill),
    .wbm_adr_i(adr), .wbm_dat_i(wdat), .wbm_sel_i(sel),
    .wbm_rdy_o(rdy_o), .wbm_ack_o(ack_o), .wbm_err_o(err_o), .wbm_tout_o(tout_o),
    .wbm_dat_o(dat_o),
    .wbs_cyc_o(cyc_o), .wbs_stb_o(stb_o), .wbs_we_o(swe_o),
    .wbs_adr_o(sadr_o), .wbs_dat_o(sdat_o), .wbs_sel_o(ssel_o),
    .wbs_dat_i(sdat_i), .wbs_ack_i(sack_i), .wbs_err_i(serr_i)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every ack/err pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (rst_n && (ack_o || err_o)) begin
      rsp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: ack=%0b err=%0b tout=%0b", ack_o, err_o, tout_o);
      end else begin
        e = exp_q.pop_front();
        if ({ack_o, err_o, tout_o, dat_o} !== e) begin
          errors++;
          $display("FAIL rsp: got ack=%0b err=%0b tout=%0b dat=0x%08h expected ack=%0b err=%0b tout=%0b dat=0x%08h",
                   ack_o, err_o, tout_o, dat_o, e.ack, e.err, e.tout, e.dat);
        end
      end
    end
  end

  task automatic issue(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    we = w; re = r; adr = a; wdat = d; sel = s;
    @(posedge clk); #1;
    we = 1'b0; re = 1'b0; adr = 32'hFFFF_FFFF; wdat = 32'hFFFF_FFFF; sel = 4'hF;
  endtask

  task automatic respond(input int nw, input logic a, input logic e, input logic k,
                         input logic [31:0] rd, output int ncyc);
    ncyc = 0;
    for (int i = 0; i < nw; i++) begin
      @(negedge clk); if (cyc_o) ncyc++;
      @(posedge clk); #1;
    end
    sack_i = a; serr_i = e; kill = k; sdat_i = rd;
    @(negedge clk); if (cyc_o) ncyc++;
    @(posedge clk); #1;
    sack_i = 1'b0; serr_i = 1'b0; kill = 1'b0; sdat_i = 32'h0BAD_0BAD;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    #12;
    chk("rst_rdy", {31'b0, rdy_o}, 32'd1);
    chk("rst_cyc_stb", {30'b0, cyc_o, stb_o}, 32'd0);
    chk("rst_ack_err_tout", {29'b0, ack_o, err_o, tout_o}, 32'd0);
    chk("rst_dat_o", dat_o, 32'd0);
    chk("rst_bus_fields", {31'b0, swe_o} | sadr_o | sdat_o | {28'b0, ssel_o}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Read, 2 wait states.
    issue(1'b0, 1'b1, 32'h100, 32'h0, 4'hF);
    chk("rd_cyc_up", {30'b0, cyc_o, stb_o}, 32'd3);
    chk("rd_rdy_low", {31'b0, rdy_o}, 32'd0);
    chk("rd_adr", sadr_o, 32'h100);
    chk("rd_we", {31'b0, swe_o}, 32'd0);
    exp_rdata = 32'hDEAD_BEEF;
    exp_q.push_back({1'b1, 1'b0, 1'b0, exp_rdata});
    respond(2, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, n);
    chk("rd_cyc_cycles", n, 32'd3);
    chk("rd_idle_after", {30'b0, cyc_o, rdy_o}, 32'd1);

    // Write, 0 wait states, then back-to-back read accepted at edge 2.
    issue(1'b1, 1'b0, 32'h40, 32'h1234_5678, 4'h3);
    chk("wr_we", {31'b0, swe_o}, 32'd1);
    chk("wr_adr", sadr_o, 32'h40);
    chk("wr_dat", sdat_o, 32'h1234_5678);
    chk("wr_sel", {28'b0, ssel_o}, 32'h3);
    exp_q.push_back({1'b1, 1'b0, 1'b0, exp_rdata});
    respond(0, 1'b1, 1'b0, 1'b0, 32'h7777_7777, n);
    chk("wr_cyc_cycles", n, 32'd1);
    chk("wr_fields_held", sadr_o, 32'h40);
    issue(1'b0, 1'b1, 32'h200, 32'h0, 4'hF);
    chk("b2b_accept", {31'b0, cyc_o}, 32'd1);
    exp_rdata = 32'hCAFE_F00D;
    exp_q.push_back({1'b1, 1'b0, 1'b0, exp_rdata});
    respond(0, 1'b1, 1'b0, 1'b0, 32'hCAFE_F00D, n);

    // ACK and ERR together: ERR wins, read data unchanged.
    issue(1'b0, 1'b1, 32'h300, 32'h0, 4'hF);
    exp_q.push_back({1'b0, 1'b1, 1'b0, exp_rdata});
    respond(2, 1'b1, 1'b1, 1'b0, 32'h5555_5555, n);
    chk("err_cyc_cycles", n, 32'd3);

    // Kill with simultaneous ACK at edge 2: no response.
    issue(1'b0, 1'b1, 32'h400, 32'h0, 4'hF);
    respond(1, 1'b1, 1'b0, 1'b1, 32'h6666_6666, n);
    chk("kill_idle", {30'b0, cyc_o, rdy_o}, 32'd1);
    @(negedge clk);
    chk("kill_no_rsp", {30'b0, ack_o, err_o}, 32'd0);
    chk("kill_dat_held", dat_o, exp_rdata);
    @(posedge clk); #1;

    // Illegal we=re=1.
    issue(1'b1, 1'b1, 32'h500, 32'h0, 4'hF);
    chk("illegal_no_cyc", {31'b0, cyc_o}, 32'd0);
    chk("illegal_rdy", {31'b0, rdy_o}, 32'd1);
    @(posedge clk); #1;
    chk("illegal_still_idle", {31'b0, cyc_o}, 32'd0);

    // Silent slave.
    issue(1'b0, 1'b1, 32'h600, 32'h0, 4'hF);
`ifdef WBM_TIMEOUT_EN
    exp_q.push_back({1'b0, 1'b1, 1'b1, exp_rdata});
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (err_o) break;
      if (cyc_o) n++;
    end
    chk("tout_cycles", n, 32'd16);
    @(posedge clk); #1;
`else
    repeat (120) @(posedge clk);
    #1;
    chk("no_wdog_cyc_held", {31'b0, cyc_o}, 32'd1);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("no_wdog_kill", {31'b0, cyc_o}, 32'd0);
`endif

    // Reset mid-transfer drops everything asynchronously.
    issue(1'b0, 1'b1, 32'h700, 32'h0, 4'hF);
    sack_i = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_cyc_stb", {30'b0, cyc_o, stb_o}, 32'd0);
    chk("arst_ack_err", {30'b0, ack_o, err_o}, 32'd0);
    chk("arst_rdy", {31'b0, rdy_o}, 32'd1);
    sack_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_rdata = 32'd0;
    chk("arst_dat_cleared", dat_o, exp_rdata);

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
